fused_op_scheduler: RTL and testbench
=====================================

Name: fused_op_scheduler

Overview:
Round-robin scheduler that shares one fused-ops datapath (MMA/CONV/ALU source plus fused ReLU/ADD stage) among N_REQ requesters.
- Accepts one command per grant.
- Selects and starts the source unit the opcode needs, drives the fused-stage opcode/operand stably, waits for the source done pulse plus the fused stage's 1-cycle register delay, then returns a tagged response.
- Sits between the instruction dispatch ports and the MMU/conv/ALU/fused-ops cluster.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 1024, max cycles in WAIT_SRC before an error response
TO_W, 11, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester command valid
req_ready  out  N_REQ  one-hot grant; a command transfers when valid&ready
req_opcode  in  8*N_REQ  flattened opcodes, requester i at [8i+7:8i]
req_inb  in  32*N_REQ  flattened operand B
src_start  out  3  one-hot 1-cycle start pulse: [0]=MMU, [1]=CONV, [2]=ALU
src_done  in  3  one-hot 1-cycle done pulse, same bit order
fu_opcode  out  8  opcode to fused stage, held stable from ISSUE through CAPTURE
fu_inb  out  32  operand B to fused stage, held stable likewise
fu_out  in  32  registered fused-stage result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_data  out  32  result (0 on error)
rsp_id  out  3  requester index that issued the command
rsp_err  out  1  1 = timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0; src_start=0; fu_opcode=0; fu_inb=0; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_err=0; round-robin pointer=0; timeout counter=0.
- Reset mid-operation aborts everything. No response is produced for the in-flight command. Late src_done after reset is ignored.
- Source map: 0x30→MMU, 0x31→CONV, 0x32→MMU, every other opcode→ALU.
- FSM:
  - IDLE: req_ready is combinational, one-hot on the first valid requester at or after the pointer (wrapping). On handshake, latch opcode, inb and id; pointer←id+1 mod N_REQ; go ISSUE. With no valid requesters, req_ready=0 and the pointer is unchanged.
  - ISSUE (1 cycle): src_start pulses the mapped bit; counter cleared; go WAIT_SRC.
  - WAIT_SRC: when src_done has the mapped bit set, go CAPTURE. src_done bits for other sources are ignored. If counter reaches TIMEOUT-1 without done: rsp_err←1, rsp_data←0, go RESP.
  - CAPTURE (1 cycle, covers the fused-stage register): the next edge samples fu_out into rsp_data, rsp_err←0; go RESP.
  - RESP: rsp_valid=1 with data/id/err stable until rsp_ready. On handshake go IDLE; req_ready stays 0 in the handshake cycle.
- Only one command is in flight; req_ready=0 outside IDLE.
- Minimum latency from accept to rsp_valid is 4 cycles (accept edge → ISSUE → WAIT_SRC with immediate done → CAPTURE → RESP).
- Simultaneous src_done with the timeout cycle: done wins (normal capture).
- src_done arriving in ISSUE is ignored; the source must respond at least 1 cycle after start.

Test Plan:
- Reset in state WAIT_SRC → all outputs 0 immediately (async); after release, a req0 command with opcode 0x31 issues src_start=3'b010.
- req0 opcode 0x30, inb=5; src_done[0] 3 cycles after start; fu_out=0x0000_0007 → rsp_valid, rsp_data=7, rsp_id=0, rsp_err=0; 6 cycles accept→rsp_valid.
- All 4 requesters held valid, rsp_ready=1 → grants in order 0,1,2,3,0. Drop req1 → order 2,3,0,2.
- Opcode 0x55 from req2 → src_start=3'b100. A src_done=3'b001 is ignored; src_done=3'b100 completes with rsp_id=2.
- No src_done with TIMEOUT=8 → rsp_err=1, rsp_data=0 exactly 8 cycles after WAIT_SRC entry. Done on the final cycle → rsp_err=0.
- rsp_ready held 0 for 10 cycles → rsp_* stable, req_ready=0 throughout; the next grant occurs only after the response handshake.

Source files
------------

// File: rtl/fused_op_scheduler.sv
// fused_op_scheduler: round-robin scheduler sharing one fused-ops datapath
// (MMU/CONV/ALU source plus registered ReLU/ADD stage) among N_REQ requesters.
// One command is in flight at a time; each response is tagged with the issuing
// requester index and flags a source timeout.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready     per-requester handshake; req_ready is a one-hot grant
//   req_opcode, req_inb     flattened per-requester opcode (8b) and operand B (32b)
//   src_start, src_done     one-hot start/done pulses: [0]=MMU [1]=CONV [2]=ALU
//   fu_opcode, fu_inb       fused-stage controls, held for the whole command
//   fu_out                  registered fused-stage result
//   rsp_valid/rsp_ready     response handshake
//   rsp_data, rsp_id        result (0 on error) and requester index
//   rsp_err                 1 = source timed out
module fused_op_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [8*N_REQ-1:0]    req_opcode,
  input  logic [32*N_REQ-1:0]   req_inb,
  output logic [2:0]            src_start,
  input  logic [2:0]            src_done,
  output logic [7:0]            fu_opcode,
  output logic [31:0]           fu_inb,
  input  logic [31:0]           fu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [2:0]            rsp_id,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SRC,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [TO_W-1:0]    r_cnt, w_cnt_nxt;
  logic [2:0]         r_src_start, w_src_start_nxt;
  logic [7:0]         r_fu_opcode, w_fu_opcode_nxt;
  logic [31:0]        r_fu_inb, w_fu_inb_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]        r_rsp_data, w_rsp_data_nxt;
  logic [IDX_W-1:0]   r_rsp_id, w_rsp_id_nxt;
  logic               r_rsp_err, w_rsp_err_nxt;

  logic [N_REQ-1:0]   w_req_ready;
  logic               w_gnt_any;
  logic [IDX_W-1:0]   w_gnt_id;
  logic [SUM_W-1:0]   w_cand;
  logic [7:0]         w_gnt_op;
  logic [31:0]        w_gnt_inb;
  logic               w_done_hit;

  // Opcode to source unit: 0x30/0x32 -> MMU, 0x31 -> CONV, anything else -> ALU.
  function automatic logic [2:0] f_src_map(input logic [7:0] op);
    logic [2:0] sel;
    case (op)
      8'h30, 8'h32: sel = 3'b001;
      8'h31:        sel = 3'b010;
      default:      sel = 3'b100;
    endcase
    return sel;
  endfunction

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_cand    = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_cand = SUM_W'(r_ptr) + SUM_W'(k);
      if (w_cand >= SUM_W'(N_REQ)) begin
        w_cand = w_cand - SUM_W'(N_REQ);
      end
      if (!w_gnt_any && req_valid[w_cand[IDX_W-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_cand[IDX_W-1:0];
      end
    end
  end

  // Pick the granted requester's opcode and operand out of the flattened buses.
  always_comb begin
    w_gnt_op  = '0;
    w_gnt_inb = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_gnt_id == IDX_W'(i)) begin
        w_gnt_op  = req_opcode[8*i +: 8];
        w_gnt_inb = req_inb[32*i +: 32];
      end
    end
  end

  // Only the source this command started may complete it.
  assign w_done_hit = |(src_done & f_src_map(r_fu_opcode));

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_src_start_nxt = 3'b000;
    w_fu_opcode_nxt = r_fu_opcode;
    w_fu_inb_nxt    = r_fu_inb;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_err_nxt   = r_rsp_err;
    w_req_ready     = '0;

    case (r_state)
      S_IDLE: begin
        if (w_gnt_any) begin
          // Grant is suppressed while reset is asserted.
          w_req_ready[w_gnt_id] = rst_n;
          w_fu_opcode_nxt       = w_gnt_op;
          w_fu_inb_nxt          = w_gnt_inb;
          w_rsp_id_nxt          = w_gnt_id;
          w_ptr_nxt             = (w_gnt_id == IDX_W'(N_REQ - 1)) ? '0
                                                                  : w_gnt_id + IDX_W'(1);
          // Start pulse is registered so it lands exactly in the ISSUE cycle.
          w_src_start_nxt       = f_src_map(w_gnt_op);
          w_state_nxt           = S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_SRC;
      end

      S_WAIT_SRC: begin
        // Done takes priority over a timeout in the same cycle.
        if (w_done_hit) begin
          w_state_nxt = S_CAPTURE;
        end else if (r_cnt == TO_W'(TIMEOUT - 1)) begin
          w_rsp_err_nxt   = 1'b1;
          w_rsp_data_nxt  = '0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + TO_W'(1);
        end
      end

      S_CAPTURE: begin
        // Fused stage has had its register cycle; fu_out is now valid.
        w_rsp_data_nxt  = fu_out;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_src_start <= 3'b000;
      r_fu_opcode <= 8'h00;
      r_fu_inb    <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_src_start <= w_src_start_nxt;
      r_fu_opcode <= w_fu_opcode_nxt;
      r_fu_inb    <= w_fu_inb_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign req_ready = w_req_ready;
  assign src_start = r_src_start;
  assign fu_opcode = r_fu_opcode;
  assign fu_inb    = r_fu_inb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = 3'(r_rsp_id);
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_fused_op_scheduler.sv
// tb_fused_op_scheduler: self-checking bench for fused_op_scheduler (N_REQ=4,
// TIMEOUT=8). A table of directed commands, hand-written sequences for reset,
// response stall and round-robin order, then random traffic checked against a
// behavioural model of arbitration, source selection and response timing.
module tb_fused_op_scheduler;

  localparam int N       = 4;
  localparam int TIMEOUT = 8;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [31:0]  req_opcode;
  logic [127:0] req_inb;
  logic [2:0]   src_start;
  logic [2:0]   src_done;
  logic [7:0]   fu_opcode;
  logic [31:0]  fu_inb;
  logic [31:0]  fu_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [2:0]   rsp_id;
  logic         rsp_err;

  fused_op_scheduler #(.N_REQ(4), .TIMEOUT(8), .TO_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_inb    (req_inb),
    .src_start  (src_start),
    .src_done   (src_done),
    .fu_opcode  (fu_opcode),
    .fu_inb     (fu_inb),
    .fu_out     (fu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;

  typedef struct {
    int          id;
    logic [7:0]  op;
    logic [31:0] inb;
    int          d;      // done arrives d cycles after start; 0 = never
    logic [2:0]  junk;   // other-source done bits in the first wait cycle
    logic [31:0] fo;
    logic [2:0]  exp_src;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: source unit chosen by opcode.
  function automatic logic [2:0] model_src(input logic [7:0] op);
    if (op == 8'h30 || op == 8'h32) return 3'b001;
    if (op == 8'h31) return 3'b010;
    return 3'b100;
  endfunction

  // Reference model: first valid requester at or after ptr, wrapping.
  function automatic int model_grant(input logic [3:0] mask, input int ptr);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (mask[j[1:0]]) return j;
    end
    return -1;
  endfunction

  // Reference model: response content and accept->rsp_valid latency.
  task automatic model_rsp(input int d, input logic [31:0] fo,
                           output logic err, output logic [31:0] data, output int lat);
    if (d >= 1 && d <= TIMEOUT) begin
      err = 1'b0; data = fo; lat = d + 3;
    end else begin
      err = 1'b1; data = 32'h0; lat = TIMEOUT + 2;
    end
  endtask

  function automatic logic [7:0] rand_op();
    int s;
    s = int'($urandom_range(0, 3));
    if (s < 3) return 8'h30 + 8'(s);
    return 8'($urandom);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; src_done = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // One command end to end. Entered at a negedge with the DUT idle.
  task automatic xact(input string nm, input int exp_id, input logic [3:0] mask,
                      input int d, input logic [2:0] junk, input logic [31:0] fo,
                      input int stall, input logic [3:0] bg, input logic [3:0] exp_next,
                      input logic [2:0] exp_src, input logic exp_err,
                      input logic [31:0] exp_data, input int exp_lat);
    bit          got;
    int          lat;
    logic [7:0]  op;
    logic [31:0] inb;
    op  = req_opcode[8*exp_id +: 8];
    inb = req_inb[32*exp_id +: 32];
    fu_out    = fo;
    req_valid = mask;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready != 4'b0000) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk({nm, "_grant"}, 64'(req_ready), 64'(4'b0001 << exp_id));
    if (!got) begin req_valid = '0; return; end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk({nm, "_start"}, 64'(src_start), 64'(exp_src));
    chk({nm, "_fuop"}, 64'(fu_opcode), 64'(op));
    chk({nm, "_fuinb"}, 64'(fu_inb), 64'(inb));
    lat = -1;
    for (int k = 2; k < 40; k++) begin
      @(posedge clk); #1;
      if (d > 0 && k == d + 1) src_done = exp_src;
      else if (k == 2)         src_done = junk;
      else                     src_done = 3'b000;
      @(negedge clk);
      if (rsp_valid) begin lat = k; break; end
    end
    src_done = 3'b000;
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_data"}, 64'(rsp_data), 64'(exp_data));
    chk({nm, "_id"}, 64'(rsp_id), 64'(exp_id));
    chk({nm, "_err"}, 64'(rsp_err), 64'(exp_err));
    req_valid = bg;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({nm, "_stall_valid"}, 64'(rsp_valid), 64'(1'b1));
      chk({nm, "_stall_data"}, 64'({rsp_err, rsp_id, rsp_data}),
          64'({exp_err, 3'(exp_id), exp_data}));
      chk({nm, "_stall_ready"}, 64'(req_ready), 64'(4'b0000));
    end
    rsp_ready = 1'b1;
    #1;
    chk({nm, "_hs_ready"}, 64'(req_ready), 64'(4'b0000));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_rsp_drop"}, 64'(rsp_valid), 64'(1'b0));
    chk({nm, "_next_grant"}, 64'(req_ready), 64'(exp_next));
    req_valid = '0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run did not complete, %0d vectors so far", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          gq[9];
    int          exp_rr[9];
    int          n_g, gid, g, d, stall, elat;
    bit          dropped;
    logic [2:0]  pend, src, junk;
    logic [3:0]  mask, bg, nxt;
    logic [31:0] fo, edata;
    logic        eerr;

    //            id  op     inb            d  junk    fo             src     err   data           lat
    tbl[0] = '{0, 8'h30, 32'd5,         3, 3'b000, 32'h0000_0007, 3'b001, 1'b0, 32'h0000_0007, 6};
    tbl[1] = '{1, 8'h31, 32'hA5A5_0001, 1, 3'b000, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'hDEAD_BEEF, 4};
    tbl[2] = '{2, 8'h55, 32'h0000_1234, 4, 3'b001, 32'h55AA_0002, 3'b100, 1'b0, 32'h55AA_0002, 7};
    tbl[3] = '{3, 8'h32, 32'hFFFF_0000, 2, 3'b000, 32'h0000_0100, 3'b001, 1'b0, 32'h0000_0100, 5};
    tbl[4] = '{0, 8'h00, 32'h1111_1111, 0, 3'b000, 32'hFFFF_FFFF, 3'b100, 1'b1, 32'h0000_0000, 10};
    tbl[5] = '{1, 8'h2F, 32'h2222_2222, 8, 3'b000, 32'h8000_0001, 3'b100, 1'b0, 32'h8000_0001, 11};
    tbl[6] = '{2, 8'h33, 32'h3333_3333, 9, 3'b000, 32'h0000_0001, 3'b100, 1'b1, 32'h0000_0000, 10};
    tbl[7] = '{3, 8'hFF, 32'h4444_4444, 5, 3'b011, 32'h0000_7777, 3'b100, 1'b0, 32'h0000_7777, 8};

    rst_n = 1'b1; req_valid = 4'hF; req_opcode = '0; req_inb = '0;
    src_done = '0; fu_out = '0; rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'(4'b0000));
    chk("rst_src_start", 64'(src_start), 64'(3'b000));
    chk("rst_fu", 64'({fu_opcode, fu_inb}), 64'(40'h0));
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_id, rsp_data}), 64'(37'h0));
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed command table.
    for (int i = 0; i < 8; i++) begin
      req_opcode[8*tbl[i].id +: 8] = tbl[i].op;
      req_inb[32*tbl[i].id +: 32]  = tbl[i].inb;
      xact($sformatf("vec%0d", i), tbl[i].id, 4'b0001 << tbl[i].id, tbl[i].d, tbl[i].junk,
           tbl[i].fo, 0, 4'b0000, 4'b0000, tbl[i].exp_src, tbl[i].exp_err,
           tbl[i].exp_data, tbl[i].exp_lat);
    end

    // Response held off for 10 cycles with req1 waiting; req1 granted only afterwards.
    req_opcode[7:0] = 8'h30; req_inb[31:0] = 32'h0000_00C3;
    xact("stall", 0, 4'b0001, 2, 3'b000, 32'hCAFE_0001, 10, 4'b0010, 4'b0010,
         3'b001, 1'b0, 32'hCAFE_0001, 5);

    // Reset while waiting on the source.
    req_opcode[7:0] = 8'h30; req_inb[31:0] = 32'h0000_00AB; req_valid = 4'b0001;
    #1;
    chk("mrst_grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("mrst_pre_fuop", 64'(fu_opcode), 64'(8'h30));
    req_valid = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_outputs", 64'({req_ready, src_start, fu_opcode, fu_inb}), 64'(47'h0));
    chk("mrst_rsp", 64'({rsp_valid, rsp_err, rsp_id, rsp_data}), 64'(37'h0));
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0; m_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      src_done = (c < 2) ? 3'b001 : 3'b000;
      @(negedge clk);
      chk($sformatf("late_done%0d", c), 64'({rsp_valid, src_start}), 64'(4'b0000));
    end
    req_opcode[7:0] = 8'h31; req_inb[31:0] = 32'h0000_0031;
    xact("post_rst", 0, 4'b0001, 2, 3'b000, 32'h0000_0310, 0, 4'b0000, 4'b0000,
         3'b010, 1'b0, 32'h0000_0310, 5);

    // Round-robin order with every requester valid, then with req1 dropped.
    do_reset();
    for (int i = 0; i < 4; i++) req_opcode[8*i +: 8] = 8'h55;
    exp_rr = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
    for (int i = 0; i < 9; i++) gq[i] = -1;
    n_g = 0; dropped = 1'b0; pend = 3'b000;
    rsp_ready = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (src_start != 3'b000) pend = src_start;
      if (req_ready != 4'b0000) begin
        gid = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i[1:0]]) gid = i;
        chk("rr_onehot", 64'($countones(req_ready)), 64'(1));
        gq[n_g] = gid;
        n_g++;
        if (n_g == 9) begin req_valid = '0; break; end
      end
      @(posedge clk); #1;
      src_done = pend; pend = 3'b000;
      if (n_g == 5 && !dropped) begin req_valid = 4'b1101; dropped = 1'b1; end
      @(negedge clk);
    end
    src_done = 3'b000; rsp_ready = 1'b0; req_valid = '0;
    for (int i = 0; i < 9; i++) chk($sformatf("rr_grant%0d", i), 64'(gq[i]), 64'(exp_rr[i]));

    // Random traffic against the reference model.
    do_reset();
    for (int t = 0; t < 60; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        req_opcode[8*i +: 8] = rand_op();
        req_inb[32*i +: 32]  = $urandom;
      end
      g     = model_grant(mask, m_ptr);
      src   = model_src(req_opcode[8*g +: 8]);
      d     = int'($urandom_range(0, 10));
      junk  = 3'($urandom_range(0, 7)) & ~src;
      fo    = $urandom;
      stall = int'($urandom_range(0, 3));
      bg    = 4'($urandom_range(0, 15));
      model_rsp(d, fo, eerr, edata, elat);
      m_ptr = (g + 1) % N;
      nxt   = (bg == 4'b0000) ? 4'b0000 : (4'b0001 << model_grant(bg, m_ptr));
      xact($sformatf("rnd%0d", t), g, mask, d, junk, fo, stall, bg, nxt,
           src, eerr, edata, elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
